// File: rtl/tcore_param.sv
// Shared widths and enums for the lowX memory-side arbitration.
package tcore_param;

    localparam int XLEN     = 32;
    localparam int BLK_SIZE = 128;

    typedef enum logic [1:0] {
        NONE,
        IC,
        DC
    } arb_owner_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// side that did not win last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_hi,   // 1 when req[1] won the previous grant
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_hi ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/lowx_arbiter.sv
// Shares one memory port between icache fill and dcache fill/writeback.
// Define LOWX_ARB_DC_PRIO_EN for fixed DC priority instead of round-robin.
module lowx_arbiter #(
    parameter int XLEN     = tcore_param::XLEN,
    parameter int BLK_SIZE = tcore_param::BLK_SIZE
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ic_req_valid_i,
    input  logic [XLEN-1:0]     ic_req_addr_i,
    input  logic                ic_req_uncached_i,
    output logic                ic_res_valid_o,
    output logic [BLK_SIZE-1:0] ic_res_blk_o,
    input  logic                dc_req_valid_i,
    input  logic                dc_req_rw_i,
    input  logic [XLEN-1:0]     dc_req_addr_i,
    input  logic                dc_req_uncached_i,
    input  logic [BLK_SIZE-1:0] dc_req_data_i,
    output logic                dc_res_valid_o,
    output logic [BLK_SIZE-1:0] dc_res_blk_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic                mem_req_rw_o,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic                mem_req_uncached_o,
    output logic [BLK_SIZE-1:0] mem_req_data_o,
    input  logic                mem_res_valid_i,
    input  logic [BLK_SIZE-1:0] mem_res_blk_i
);

    import tcore_param::*;

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic                rw_q, rw_d;
    logic                unc_q, unc_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [BLK_SIZE-1:0] data_q, data_d;
    logic [1:0]          req, gnt;
    logic                complete;

    assign req = {dc_req_valid_i, ic_req_valid_i};

`ifdef LOWX_ARB_DC_PRIO_EN
    // DC always wins a tie; icache may starve under sustained dcache traffic.
    assign gnt = req[1] ? 2'b10 : {1'b0, req[0]};
`else
    arb_owner_e last_q, last_d;

    rr_arb2 u_rr (
        .req     (req),
        .last_hi (last_q == DC),
        .gnt     (gnt)
    );

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE) begin
            if (gnt[1])      last_d = DC;
            else if (gnt[0]) last_d = IC;
        end
    end

    // Starting at IC makes the first tie after reset go to DC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= IC;
        else       last_q <= last_d;
    end
`endif

    always_comb begin
        state_d            = state_q;
        owner_d            = owner_q;
        rw_d               = rw_q;
        unc_d              = unc_q;
        addr_d             = addr_q;
        data_d             = data_q;
        complete           = 1'b0;
        mem_req_valid_o    = 1'b0;
        mem_req_rw_o       = 1'b0;
        mem_req_addr_o     = '0;
        mem_req_uncached_o = 1'b0;
        mem_req_data_o     = '0;

        case (state_q)
            IDLE: begin
                if (gnt[1]) begin
                    rw_d    = dc_req_rw_i;
                    unc_d   = dc_req_uncached_i;
                    addr_d  = dc_req_addr_i;
                    data_d  = dc_req_data_i;
                    owner_d = DC;
                    state_d = REQ;
                end else if (gnt[0]) begin
                    rw_d    = 1'b0;
                    unc_d   = ic_req_uncached_i;
                    addr_d  = ic_req_addr_i;
                    data_d  = '0;
                    owner_d = IC;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_valid_o    = 1'b1;
                mem_req_rw_o       = rw_q;
                mem_req_addr_o     = addr_q;
                mem_req_uncached_o = unc_q;
                mem_req_data_o     = data_q;
                if (mem_req_ready_i) begin
                    if (mem_res_valid_i) begin
                        complete = 1'b1;
                        owner_d  = NONE;
                        state_d  = IDLE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_res_valid_i) begin
                    complete = 1'b1;
                    owner_d  = NONE;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= NONE;
            rw_q    <= 1'b0;
            unc_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            unc_q   <= unc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Responses are steered combinationally so the pulse lands in the completing cycle.
    assign ic_res_valid_o = complete && (owner_q == IC);
    assign dc_res_valid_o = complete && (owner_q == DC);
    assign ic_res_blk_o   = ic_res_valid_o ? mem_res_blk_i : '0;
    assign dc_res_blk_o   = dc_res_valid_o ? mem_res_blk_i : '0;

endmodule

// File: tb/tb_lowx_arbiter.sv
// Randomized bench for lowx_arbiter against a transaction-level arbitration model.
module tb_lowx_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         ic_req_valid_i, ic_req_uncached_i;
    logic [31:0]  ic_req_addr_i;
    logic         ic_res_valid_o;
    logic [127:0] ic_res_blk_o;
    logic         dc_req_valid_i, dc_req_rw_i, dc_req_uncached_i;
    logic [31:0]  dc_req_addr_i;
    logic [127:0] dc_req_data_i;
    logic         dc_res_valid_o;
    logic [127:0] dc_res_blk_o;
    logic         mem_req_valid_o, mem_req_ready_i, mem_req_rw_o, mem_req_uncached_o;
    logic [31:0]  mem_req_addr_o;
    logic [127:0] mem_req_data_o;
    logic         mem_res_valid_i;
    logic [127:0] mem_res_blk_i;

    int n_chk  = 0;
    int n_pass = 0;
    int last_w = 1;      // model: 1 = IC won last, 2 = DC won last
    bit stray  = 1'b0;   // drive a stray memory response in the IDLE cycle

    lowx_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
        .ic_req_uncached_i(ic_req_uncached_i),
        .ic_res_valid_o(ic_res_valid_o), .ic_res_blk_o(ic_res_blk_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_rw_i(dc_req_rw_i),
        .dc_req_addr_i(dc_req_addr_i), .dc_req_uncached_i(dc_req_uncached_i),
        .dc_req_data_i(dc_req_data_i),
        .dc_res_valid_o(dc_res_valid_o), .dc_res_blk_o(dc_res_blk_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_rw_o(mem_req_rw_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_uncached_o(mem_req_uncached_o), .mem_req_data_o(mem_req_data_o),
        .mem_res_valid_i(mem_res_valid_i), .mem_res_blk_i(mem_res_blk_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Arbitration rule: lone requester wins; tie alternates (or DC under fixed priority).
    function automatic int pick(input bit icv, input bit dcv);
        if (icv && dcv) begin
`ifdef LOWX_ARB_DC_PRIO_EN
            return 2;
`else
            return (last_w == 1) ? 2 : 1;
`endif
        end
        if (dcv) return 2;
        if (icv) return 1;
        return 0;
    endfunction

    task automatic chk_res(input int w, input logic [127:0] blk);
        chk("ic_res_valid", ic_res_valid_o, (w == 1));
        chk("ic_res_blk",   ic_res_blk_o,   (w == 1) ? blk : 128'd0);
        chk("dc_res_valid", dc_res_valid_o, (w == 2));
        chk("dc_res_blk",   dc_res_blk_o,   (w == 2) ? blk : 128'd0);
    endtask

    task automatic chk_req(input logic [31:0] a, input logic rw, input logic u, input logic [127:0] d);
        chk("req_valid", mem_req_valid_o, 1'b1);
        chk("req_addr",  mem_req_addr_o,  a);
        chk("req_rw",    mem_req_rw_o,    rw);
        chk("req_unc",   mem_req_uncached_o, u);
        chk("req_data",  mem_req_data_o,  d);
    endtask

    task automatic scramble();
        ic_req_valid_i    = 1'($urandom_range(0, 1));
        dc_req_valid_i    = 1'($urandom_range(0, 1));
        ic_req_addr_i     = $urandom;
        dc_req_addr_i     = $urandom;
        ic_req_uncached_i = 1'($urandom_range(0, 1));
        dc_req_uncached_i = 1'($urandom_range(0, 1));
        dc_req_rw_i       = 1'($urandom_range(0, 1));
        dc_req_data_i     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One transaction starting in an IDLE cycle with request inputs already set.
    // rdly: cycles of ready=0 in REQ; rsdly: cycles from accept to response (0 = same cycle).
    task automatic txn(input int rdly, input int rsdly, input logic [127:0] blk, input bit wiggle);
        int w;
        logic [31:0]  ea;
        logic         erw, eu;
        logic [127:0] ed;
        mem_req_ready_i = 1'b0;
        mem_res_valid_i = stray;
        mem_res_blk_i   = blk;
        #1;
        chk("idle_req_valid", mem_req_valid_o, 1'b0);
        chk_res(0, blk);
        w = pick(ic_req_valid_i, dc_req_valid_i);
        if (w == 2) begin
            ea = dc_req_addr_i; erw = dc_req_rw_i; eu = dc_req_uncached_i; ed = dc_req_data_i;
        end else begin
            ea = ic_req_addr_i; erw = 1'b0; eu = ic_req_uncached_i; ed = 128'd0;
        end
        if (w != 0) last_w = w;
        tick();
        mem_res_valid_i = 1'b0;
        if (w == 0) return;
        for (int k = 0; k < rdly; k++) begin
            if (wiggle) scramble();
            #1;
            chk_req(ea, erw, eu, ed);
            chk_res(0, blk);
            tick();
        end
        mem_req_ready_i = 1'b1;
        mem_res_valid_i = (rsdly == 0);
        #1;
        chk_req(ea, erw, eu, ed);
        chk_res((rsdly == 0) ? w : 0, blk);
        tick();
        mem_req_ready_i = 1'b0;
        mem_res_valid_i = 1'b0;
        if (rsdly > 0) begin
            for (int k = 1; k < rsdly; k++) begin
                if (wiggle) scramble();
                #1;
                chk("wait_req_valid", mem_req_valid_o, 1'b0);
                chk_res(0, blk);
                tick();
            end
            mem_res_valid_i = 1'b1;
            #1;
            chk("wait_req_valid", mem_req_valid_o, 1'b0);
            chk_res(w, blk);
            tick();
            mem_res_valid_i = 1'b0;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        ic_req_valid_i = 0; ic_req_addr_i = 0; ic_req_uncached_i = 0;
        dc_req_valid_i = 0; dc_req_rw_i = 0; dc_req_addr_i = 0;
        dc_req_uncached_i = 0; dc_req_data_i = 0;
        mem_req_ready_i = 0; mem_res_valid_i = 0; mem_res_blk_i = 0;
        #2;
        chk("rst_req_valid", mem_req_valid_o, 1'b0);
        chk("rst_req_addr",  mem_req_addr_o,  32'd0);
        chk("rst_req_data",  mem_req_data_o,  128'd0);
        chk_res(0, 128'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // IC alone, response four cycles after accept
        ic_req_valid_i = 1; ic_req_addr_i = 32'h8000_0040;
        txn(0, 4, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF, 0);

        // simultaneous requests alternate
        for (int r = 0; r < 4; r++) begin
            ic_req_valid_i = 1; ic_req_addr_i = 32'h200;
            dc_req_valid_i = 1; dc_req_addr_i = 32'h100; dc_req_rw_i = 0;
            txn(r % 2, 1 + r, {4{$urandom}}, 0);
        end

        // DC writeback held off by ready, with inputs changing underneath
        ic_req_valid_i = 0;
        dc_req_valid_i = 1; dc_req_rw_i = 1; dc_req_addr_i = 32'h4000_0080;
        dc_req_data_i = {32{4'h1}};
        txn(5, 2, 128'h0, 1);

        // accept and respond in the same cycle, stray response in the next IDLE
        ic_req_valid_i = 1; dc_req_valid_i = 0; ic_req_addr_i = 32'h0000_1230;
        txn(0, 0, 128'hCAFE, 0);
        stray = 1'b1;
        ic_req_valid_i = 0;
        txn(0, 0, 128'hBAD, 0);
        stray = 1'b0;

        // reset while waiting for the response
        ic_req_valid_i = 1; ic_req_addr_i = 32'h300;
        tick();
        mem_req_ready_i = 1;
        tick();
        mem_req_ready_i = 0;
        ic_req_valid_i = 0;
        rst_i = 1'b1; mem_res_valid_i = 1'b1; mem_res_blk_i = 128'h5555;
        #1;
        chk("rst_wait_req_valid", mem_req_valid_o, 1'b0);
        chk_res(0, 128'h5555);
        tick();
        rst_i = 1'b0;
        last_w = 1;
        #1;
        chk("post_rst_req_valid", mem_req_valid_o, 1'b0);
        chk_res(0, 128'h5555);
        tick();
        ic_req_valid_i = 1; ic_req_addr_i = 32'h8000_0100; ic_req_uncached_i = 1;
        txn(1, 1, 128'h7777, 0);
        ic_req_valid_i = 1; dc_req_valid_i = 1; dc_req_rw_i = 0; dc_req_addr_i = 32'h500;
        txn(0, 1, 128'h8888, 0);

        for (int i = 0; i < 150; i++) begin
            scramble();
            stray = ($urandom_range(0, 3) == 0);
            txn($urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom, $urandom, $urandom}, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
